rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the minimal RV32I subset: ADD, SUB, ADDI, SLLI, SRLI, SRAI, BEQ, BNE, LUI.
- Fetches each instruction over a req/ack instruction-memory handshake, decodes it, and reads the register file.
- Executes through an internal adder/comparator and a 1-bit-per-cycle iterative shifter, then writes back and advances the PC.
- Sits between instruction memory and the register file as the core's only control FSM.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request; held until ack
imem_addr  out  32  fetch address (= pc while imem_req)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  instruction word, sampled when imem_ack=1
rf_raddr1  out  5  rs1 index (ir[19:15])
rf_raddr2  out  5  rs2 index (ir[24:20])
rf_rdata1  in  32  rs1 data, combinational from rf_raddr1
rf_rdata2  in  32  rs2 data, combinational from rf_raddr2
rf_we  out  1  register write strobe, one cycle
rf_waddr  out  5  rd index
rf_wdata  out  32  write-back data
pc  out  32  current PC
illegal  out  1  sticky trap flag

Behaviour:
- One clock, clk. Reset is asynchronous and active-high.
- Reset values: state=FETCH, pc=RESET_PC, imem_req=0 during reset, rf_we=0, illegal=0, ir=0.
- A reset asserted mid-operation aborts at once. No write-back completes and the PC does not advance.

States:
- FETCH: imem_req=1, imem_addr=pc. Wait while imem_ack=0. Ack may arrive in the first FETCH cycle. On ack, latch ir<=imem_rdata and go to DECODE.
- DECODE: rf_raddr1/2 driven from ir. Latch A<=rf_rdata1, B<=rf_rdata2, and the I/B/U immediates (sign-extended).
  - Opcode/funct3/funct7 must match the subset exactly. SLLI/SRLI/SRAI also require ir[25]=0.
  - No match: go to TRAP.
  - Shift with shamt=ir[24:20]>0: load cnt<=shamt, go to SHIFT.
  - Otherwise: go to EXEC.
- EXEC: compute result in one cycle, then go to WB.
  - ADD: A+B. SUB: A-B. ADDI: A+immI. All mod 2^32.
  - LUI: {ir[31:12],12'b0}.
  - Shift with shamt=0: result A.
  - BEQ/BNE: taken = (A==B) for BEQ, (A!=B) for BNE; target = pc + immB.
- SHIFT: each cycle shift the result register 1 bit and decrement cnt.
  - SLLI shifts left with zero fill. SRLI shifts right with zero fill. SRAI shifts right replicating bit 31.
  - Go to WB the cycle cnt reaches 1. Total SHIFT cycles = shamt.
- WB: one cycle.
  - Non-branch: rf_we=1 with rf_waddr=ir[11:7] and rf_wdata=result. rf_we is suppressed when rd=0.
  - Non-branch and not-taken branch: pc<=pc+4.
  - Taken branch: if target[1]=1, go to TRAP without updating pc. Otherwise pc<=target.
  - Branches never assert rf_we. After WB, return to FETCH.
- TRAP: illegal=1, imem_req=0, rf_we=0, pc frozen at the faulting instruction. Exit only through reset.

Latency and arithmetic:
- Latency with zero-wait ack: 4 cycles per instruction (FETCH, DECODE, EXEC, WB). Shifts with shamt n>0 take 3+n cycles.
- Each extra cycle imem_ack is low adds one cycle in FETCH.
- pc arithmetic wraps mod 2^32: pc=32'hFFFF_FFFC plus 4 gives 0.
- rf_wdata is don't-care when rf_we=0. rf_raddr1/2 are don't-care outside DECODE.

Test Plan:
- Reset, then ack with 0 wait, ir=ADDI x1,x0,5 (rf_rdata1=0) -> rf_we=1 with waddr=1, wdata=5 in cycle 4; pc=4; imem_req reasserts in cycle 5.
- ir=SRAI x2,x1,31 with rs1=32'h8000_0000 -> 31 SHIFT cycles; WB wdata=32'hFFFF_FFFF; total 34 cycles. Repeat as SLLI with shamt=0 -> wdata=rs1, 4 cycles.
- BEQ with rs1=rs2=7, immB=-8, pc=0x20 -> no rf_we; pc=0x18. Same instruction with rs2=8 -> pc=0x24.
- BNE taken with immB=+6 (target bit1 set) -> illegal=1, pc stays at the branch address, imem_req=0 for 20 cycles; reset clears illegal and sets pc=RESET_PC.
- imem_ack low for 3 cycles -> imem_req and imem_addr held steady; ir latched on the ack edge only. Also: SUB with rd=0 -> rf_we stays 0.
- Unsupported word 32'h0000_0073 (ECALL), and SLLI with ir[25]=1 -> TRAP from DECODE. Reset asserted during SHIFT -> rf_we never pulses; FETCH at RESET_PC after release.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// rv_multicycle_ctrl : multi-cycle fetch/decode/execute/write-back sequencer
//                      for a minimal RV32I subset with an iterative shifter.
// Revision: 1.0
// ============================================================================
module rv_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        illegal
);

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_F7_ZERO    = 7'b0000000;
  localparam logic [6:0] c_F7_ALT     = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_SHIFT  = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_ADDI = 4'd3,
    OP_SLLI = 4'd4,
    OP_SRLI = 4'd5,
    OP_SRAI = 4'd6,
    OP_BEQ  = 4'd7,
    OP_BNE  = 4'd8,
    OP_LUI  = 4'd9
  } op_t;

  state_t      r_state;
  op_t         r_op;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_imm_i;
  logic [31:0] r_imm_b;
  logic [31:0] r_imm_u;
  logic [31:0] r_result;
  logic [31:0] r_target;
  logic [4:0]  r_cnt;
  logic        r_taken;
  logic        r_rf_we;
  logic        r_illegal;

  op_t         w_op;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_shamt;
  logic [4:0]  w_rd;
  logic        w_dec_shift;
  logic        w_is_branch;

  assign w_opcode = r_ir[6:0];
  assign w_funct3 = r_ir[14:12];
  assign w_funct7 = r_ir[31:25];
  assign w_shamt  = r_ir[24:20];
  assign w_rd     = r_ir[11:7];

  // Exact-match decoder; the funct7 check on shifts also rejects ir[25]=1.
  always_comb begin
    w_op = OP_NONE;
    case (w_opcode)
      c_OPC_OP: begin
        if (w_funct3 == 3'b000 && w_funct7 == c_F7_ZERO) w_op = OP_ADD;
        else if (w_funct3 == 3'b000 && w_funct7 == c_F7_ALT) w_op = OP_SUB;
      end
      c_OPC_OP_IMM: begin
        if (w_funct3 == 3'b000) w_op = OP_ADDI;
        else if (w_funct3 == 3'b001 && w_funct7 == c_F7_ZERO) w_op = OP_SLLI;
        else if (w_funct3 == 3'b101 && w_funct7 == c_F7_ZERO) w_op = OP_SRLI;
        else if (w_funct3 == 3'b101 && w_funct7 == c_F7_ALT) w_op = OP_SRAI;
      end
      c_OPC_BRANCH: begin
        if (w_funct3 == 3'b000) w_op = OP_BEQ;
        else if (w_funct3 == 3'b001) w_op = OP_BNE;
      end
      c_OPC_LUI: w_op = OP_LUI;
      default: w_op = OP_NONE;
    endcase
  end

  assign w_dec_shift = (w_op == OP_SLLI) || (w_op == OP_SRLI) || (w_op == OP_SRAI);
  assign w_is_branch = (r_op == OP_BEQ) || (r_op == OP_BNE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_op      <= OP_NONE;
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_imm_i   <= 32'd0;
      r_imm_b   <= 32'd0;
      r_imm_u   <= 32'd0;
      r_result  <= 32'd0;
      r_target  <= 32'd0;
      r_cnt     <= 5'd0;
      r_taken   <= 1'b0;
      r_rf_we   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_rf_we <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a      <= rf_rdata1;
          r_b      <= rf_rdata2;
          r_result <= rf_rdata1;
          r_imm_i  <= {{20{r_ir[31]}}, r_ir[31:20]};
          r_imm_b  <= {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
          r_imm_u  <= {r_ir[31:12], 12'd0};
          r_op     <= w_op;
          r_cnt    <= w_shamt;
          if (w_op == OP_NONE) begin
            r_illegal <= 1'b1;
            r_state   <= S_TRAP;
          end else if (w_dec_shift && w_shamt != 5'd0) begin
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_ADD:  r_result <= r_a + r_b;
            OP_SUB:  r_result <= r_a - r_b;
            OP_ADDI: r_result <= r_a + r_imm_i;
            OP_LUI:  r_result <= r_imm_u;
            default: r_result <= r_a;
          endcase
          r_taken  <= (r_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);
          r_target <= r_pc + r_imm_b;
          r_rf_we  <= !w_is_branch && (w_rd != 5'd0);
          r_state  <= S_WB;
        end
        S_SHIFT: begin
          case (r_op)
            OP_SLLI: r_result <= {r_result[30:0], 1'b0};
            OP_SRAI: r_result <= {r_result[31], r_result[31:1]};
            default: r_result <= {1'b0, r_result[31:1]};
          endcase
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_rf_we <= (w_rd != 5'd0);
            r_state <= S_WB;
          end
        end
        S_WB: begin
          // A taken branch to a non-word-aligned target traps with pc frozen.
          if (w_is_branch && r_taken) begin
            if (r_target[1]) begin
              r_illegal <= 1'b1;
              r_state   <= S_TRAP;
            end else begin
              r_pc    <= r_target;
              r_state <= S_FETCH;
            end
          end else begin
            r_pc    <= r_pc + 32'd4;
            r_state <= S_FETCH;
          end
        end
        S_TRAP: r_state <= S_TRAP;
        default: begin
          r_illegal <= 1'b1;
          r_state   <= S_TRAP;
        end
      endcase
    end
  end

  // Request is qualified by reset so it stays low while reset is held.
  assign imem_req  = (r_state == S_FETCH) && !reset;
  assign imem_addr = r_pc;
  assign rf_raddr1 = r_ir[19:15];
  assign rf_raddr2 = r_ir[24:20];
  assign rf_we     = r_rf_we;
  assign rf_waddr  = w_rd;
  assign rf_wdata  = r_result;
  assign pc        = r_pc;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rv_multicycle_ctrl : directed table-driven bench for rv_multicycle_ctrl.
// Revision: 1.0
// ============================================================================
module tb_rv_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pc;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  rv_multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc0;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    int          waits;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc1;
    int          cyc;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge in the first FETCH cycle; returns at the negedge of
  // the next FETCH cycle (or the first TRAP cycle).
  task automatic run_instr(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                           input int waits, output int cyc, output int we_cnt,
                           output logic [4:0] wa, output logic [31:0] wd);
    logic [31:0] addr0;
    cyc = 0; we_cnt = 0; wa = 5'd0; wd = 32'd0;
    addr0 = imem_addr;
    rf_rdata1 = a;
    rf_rdata2 = b;
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      imem_rdata = 32'h0000_0073;
      @(negedge clk);
      cyc++;
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, addr0);
    end
    imem_ack = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    cyc++;
    imem_ack = 1'b0;
    imem_rdata = 32'h0000_0073;
    while (!imem_req && !illegal && cyc < 100) begin
      if (rf_we) begin
        we_cnt++;
        wa = rf_waddr;
        wd = rf_wdata;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: instr %h did not complete, cycles %0d required < 100", instr, cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
  endtask

  initial begin
    int cyc, we_cnt;
    logic [4:0] wa;
    logic [31:0] wd;

    //          pc0       instr         a             b       w  we wa     wd            pc1       cyc
    vecs[0]  = '{32'h00, 32'h00500093, 32'h0,        32'h0,  0, 1, 5'd1,  32'd5,        32'h04,   4}; // ADDI x1,x0,5
    vecs[1]  = '{32'h04, 32'h41F0D113, 32'h80000000, 32'h0,  0, 1, 5'd2,  32'hFFFFFFFF, 32'h08,  34}; // SRAI x2,x1,31
    vecs[2]  = '{32'h08, 32'h00009193, 32'h12345678, 32'h0,  0, 1, 5'd3,  32'h12345678, 32'h0C,   4}; // SLLI x3,x1,0
    vecs[3]  = '{32'h0C, 32'h40208033, 32'd9,        32'd3,  3, 0, 5'd0,  32'd0,        32'h10,   7}; // SUB x0 + 3 waits
    vecs[4]  = '{32'h10, 32'h00208233, 32'hFFFFFFFF, 32'd2,  0, 1, 5'd4,  32'd1,        32'h14,   4}; // ADD wraps
    vecs[5]  = '{32'h14, 32'hABCDE2B7, 32'h0,        32'h0,  1, 1, 5'd5,  32'hABCDE000, 32'h18,   5}; // LUI + 1 wait
    vecs[6]  = '{32'h18, 32'h0040D313, 32'hF00000F0, 32'h0,  0, 1, 5'd6,  32'h0F00000F, 32'h1C,   7}; // SRLI 4
    vecs[7]  = '{32'h1C, 32'hFFF08393, 32'h0,        32'h0,  0, 1, 5'd7,  32'hFFFFFFFF, 32'h20,   4}; // ADDI -1
    vecs[8]  = '{32'h20, 32'hFE208CE3, 32'd7,        32'd7,  0, 0, 5'd0,  32'd0,        32'h18,   4}; // BEQ taken -8
    vecs[9]  = '{32'h18, 32'h00309493, 32'h80000001, 32'h0,  0, 1, 5'd9,  32'h00000008, 32'h1C,   6}; // SLLI 3
    vecs[10] = '{32'h1C, 32'h4010D513, 32'h80000004, 32'h0,  2, 1, 5'd10, 32'hC0000002, 32'h20,   6}; // SRAI 1 + 2 waits
    vecs[11] = '{32'h20, 32'hFE208CE3, 32'd7,        32'd8,  0, 0, 5'd0,  32'd0,        32'h24,   4}; // BEQ not taken
    vecs[12] = '{32'h24, 32'h00209463, 32'd5,        32'd5,  0, 0, 5'd0,  32'd0,        32'h28,   4}; // BNE not taken
    vecs[13] = '{32'h28, 32'h00209463, 32'd5,        32'd6,  0, 0, 5'd0,  32'd0,        32'h30,   4}; // BNE taken +8
    vecs[14] = '{32'h30, 32'h402085B3, 32'd5,        32'd7,  0, 1, 5'd11, 32'hFFFFFFFE, 32'h34,   4}; // SUB x11

    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    rf_rdata1 = 32'h0;
    rf_rdata2 = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_we", {31'd0, rf_we}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    chk("reset_pc", pc, 32'h0);
    reset = 1'b0;
    #1;

    for (int i = 0; i < 15; i++) begin
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].pc0);
      run_instr(vecs[i].instr, vecs[i].a, vecs[i].b, vecs[i].waits, cyc, we_cnt, wa, wd);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_we_count", i), we_cnt, vecs[i].we ? 32'd1 : 32'd0);
      if (vecs[i].we) begin
        chk($sformatf("v%0d_waddr", i), {27'd0, wa}, {27'd0, vecs[i].wa});
        chk($sformatf("v%0d_wdata", i), wd, vecs[i].wd);
      end
      chk($sformatf("v%0d_pc", i), pc, vecs[i].pc1);
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, 32'd0);
    end

    // BNE taken with +6 from 0x34: misaligned target traps.
    run_instr(32'h00209363, 32'd5, 32'd6, 0, cyc, we_cnt, wa, wd);
    chk("bne_trap_illegal", {31'd0, illegal}, 32'd1);
    chk("bne_trap_pc", pc, 32'h34);
    chk("bne_trap_we", we_cnt, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("trap_req", {31'd0, imem_req}, 32'd0);
      chk("trap_pc", pc, 32'h34);
      chk("trap_we", {31'd0, rf_we}, 32'd0);
      chk("trap_illegal", {31'd0, illegal}, 32'd1);
    end
    do_reset();

    // ECALL is outside the subset.
    run_instr(32'h0000_0073, 32'd0, 32'd0, 0, cyc, we_cnt, wa, wd);
    chk("ecall_illegal", {31'd0, illegal}, 32'd1);
    chk("ecall_pc", pc, 32'h0);
    chk("ecall_cycles", cyc, 32'd2);
    do_reset();

    // SLLI with ir[25]=1.
    run_instr(32'h02009193, 32'd1, 32'd0, 0, cyc, we_cnt, wa, wd);
    chk("slli25_illegal", {31'd0, illegal}, 32'd1);
    chk("slli25_we", we_cnt, 32'd0);
    do_reset();

    // Reset asserted in the middle of a 31-step shift.
    rf_rdata1 = 32'h8000_0000;
    imem_ack = 1'b1;
    imem_rdata = 32'h41F0D113;
    @(negedge clk);
    imem_ack = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (rf_we) we_cnt++;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("midshift_we", we_cnt + {31'd0, rf_we}, 32'd0);
    chk("midshift_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("midshift_pc", pc, 32'h0);
    reset = 1'b0;
    #1;
    chk("midshift_refetch_req", {31'd0, imem_req}, 32'd1);
    chk("midshift_refetch_addr", imem_addr, 32'h0);
    run_instr(32'h00500093, 32'd0, 32'd0, 0, cyc, we_cnt, wa, wd);
    chk("after_reset_wdata", wd, 32'd5);
    chk("after_reset_pc", pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
